pipe_issue_sched: RTL

- Issue scheduler in front of the 4-stage regbank/ALU/memory pipeline.
- Arbitrates between two instruction requesters using round-robin with skip-ahead.
- Blocks read-after-write hazards against in-flight destinations with a destination scoreboard.
- Presents one registered instruction per cycle to pipeline stage 1 and keeps a saturating stall counter for debug.

---
 rtl/pipe_issue_sched.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pipe_issue_sched.sv
// Issue scheduler: round-robin arbitration with skip-ahead between two requesters,
// RAW blocking against a destination scoreboard, one registered issue per cycle.
module pipe_issue_sched #(
  parameter int RW        = 4,
  parameter int FW        = 4,
  parameter int AW        = 8,
  parameter int HAZ_DEPTH = 3,
  parameter int SCW       = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [RW-1:0]   req0_rs1,
  input  logic [RW-1:0]   req0_rs2,
  input  logic [RW-1:0]   req0_rd,
  input  logic [FW-1:0]   req0_func,
  input  logic [AW-1:0]   req0_addr,
  input  logic [RW-1:0]   req1_rs1,
  input  logic [RW-1:0]   req1_rs2,
  input  logic [RW-1:0]   req1_rd,
  input  logic [FW-1:0]   req1_func,
  input  logic [AW-1:0]   req1_addr,
  output logic            iss_valid,
  output logic [RW-1:0]   iss_rs1,
  output logic [RW-1:0]   iss_rs2,
  output logic [RW-1:0]   iss_rd,
  output logic [FW-1:0]   iss_func,
  output logic [AW-1:0]   iss_addr,
  output logic            iss_src,
  output logic [SCW-1:0]  stall_cnt
);

  // Entry i holds the destination of the instruction issued i+1 cycles ago.
  logic [HAZ_DEPTH-1:0] sb_v;
  logic [RW-1:0]        sb_rd [HAZ_DEPTH];

  logic          rr_ptr;
  logic [1:0]    blk;
  logic [1:0]    elig;
  logic [1:0]    grant;
  logic          grant_any;
  logic          gsel;
  logic [RW-1:0] g_rs1, g_rs2, g_rd;
  logic [FW-1:0] g_func;
  logic [AW-1:0] g_addr;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    blk = 2'b00;
    for (int i = 0; i < HAZ_DEPTH; i++) begin
      if (sb_v[i]) begin
        if (req0_rs1 == sb_rd[i] || req0_rs2 == sb_rd[i]) blk[0] = 1'b1;
        if (req1_rs1 == sb_rd[i] || req1_rs2 == sb_rd[i]) blk[1] = 1'b1;
      end
    end
    blk  = blk & req_valid;
    elig = req_valid & ~blk;
  end

  // Preferred requester first, otherwise skip ahead to the other one.
  always_comb begin
    grant = 2'b00;
    if (rst_n && !flush) begin
      if (elig[rr_ptr])       grant[rr_ptr]  = 1'b1;
      else if (elig[~rr_ptr]) grant[~rr_ptr] = 1'b1;
    end
  end

  assign req_ready = grant;
  assign grant_any = |grant;
  assign gsel      = grant[1];

  always_comb begin
    g_rs1  = req0_rs1;
    g_rs2  = req0_rs2;
    g_rd   = req0_rd;
    g_func = req0_func;
    g_addr = req0_addr;
    if (gsel) begin
      g_rs1  = req1_rs1;
      g_rs2  = req1_rs2;
      g_rd   = req1_rd;
      g_func = req1_func;
      g_addr = req1_addr;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid <= 1'b0;
      iss_rs1   <= '0;
      iss_rs2   <= '0;
      iss_rd    <= '0;
      iss_func  <= '0;
      iss_addr  <= '0;
      iss_src   <= 1'b0;
      rr_ptr    <= 1'b0;
      sb_v      <= '0;
      stall_cnt <= '0;
    end else begin
      iss_valid <= grant_any;
      if (grant_any) begin
        iss_rs1  <= g_rs1;
        iss_rs2  <= g_rs2;
        iss_rd   <= g_rd;
        iss_func <= g_func;
        iss_addr <= g_addr;
        iss_src  <= gsel;
        rr_ptr   <= ~gsel;
      end
      if (flush) sb_v <= '0;
      else       sb_v <= {sb_v[HAZ_DEPTH-2:0], grant_any};
      if (req_valid != 2'b00 && !grant_any && stall_cnt != '1)
        stall_cnt <= stall_cnt + SCW'(1);
    end
  end

  // NOTE: only the valid bits need reset; a stale rd behind a cleared valid is never compared.
  always_ff @(posedge clk) begin
    sb_rd[0] <= g_rd;
    for (int i = 1; i < HAZ_DEPTH; i++) sb_rd[i] <= sb_rd[i-1];
  end

endmodule
